reg8_bank: RTL and testbench

- Eight-entry, 8-bit register bank for the reg8file design.
- Sits directly upstream of the 8:1 read-select stage; its outputs r0..r7 drive that stage's data inputs.
- Two ways to write:
  - a random-access write port (we/wsel/wdata);
  - a burst-fill engine that loads r0..r7 in order from a valid/ready byte stream.
- A synchronous clear-all with abort.

---
 rtl/reg8_bank.sv | 154 +++++++++++++++
 tb/tb_reg8_bank.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/reg8_bank.sv
`default_nettype none
// ============================================================================
// Module   : reg8_bank
// Purpose  : Eight-entry register bank feeding the 8:1 read-select stage.
//            Loaded either by a random-access write port or by a burst-fill
//            engine that takes r0..r7 in order from a valid/ready byte
//            stream. A synchronous clear wipes the bank and aborts a burst.
// Revision : 1.0 - initial release
// ============================================================================
module reg8_bank #(
    parameter int WIDTH = 8,
    parameter int SEL_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             we,
    input  logic [SEL_W-1:0] wsel,
    input  logic [WIDTH-1:0] wdata,
    input  logic             burst_start,
    input  logic             s_valid,
    input  logic [WIDTH-1:0] s_data,
    output logic             s_ready,
    output logic             busy,
    output logic             done,
    output logic             wr_err,
    output logic [WIDTH-1:0] r0,
    output logic [WIDTH-1:0] r1,
    output logic [WIDTH-1:0] r2,
    output logic [WIDTH-1:0] r3,
    output logic [WIDTH-1:0] r4,
    output logic [WIDTH-1:0] r5,
    output logic [WIDTH-1:0] r6,
    output logic [WIDTH-1:0] r7
);

    // Burst engine state encoding
    localparam logic [1:0] c_s_idle = 2'd0;
    localparam logic [1:0] c_s_fill = 2'd1;
    localparam logic [1:0] c_s_done = 2'd2;

    localparam logic [2:0] c_ptr_last = 3'd7;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [2:0]       r_ptr;
    logic [2:0]       w_ptr_nxt;
    logic [WIDTH-1:0] r_regs [8];
    logic             r_wr_err;
    logic             w_wr_err_nxt;
    logic             w_sel_ok;
    logic             w_idle;
    logic             w_single;
    logic             w_accept;

    // Only indices 0..7 address a register; any set upper bit is out of range.
    generate
        if (SEL_W > 3) begin : g_sel_wide
            assign w_sel_ok = ~|wsel[SEL_W-1:3];
        end else begin : g_sel_narrow
            assign w_sel_ok = 1'b1;
        end
    endgenerate

    assign w_idle   = (r_state == c_s_idle);
    assign w_single = w_idle && we && w_sel_ok && !clr;
    assign w_accept = (r_state == c_s_fill) && s_valid && !clr;

    // A write is rejected when out of range or when the burst engine owns the
    // bank; clr suppresses the error pulse.
    assign w_wr_err_nxt = !clr && we && (!w_idle || !w_sel_ok);

    // Next-state and pointer decode for the burst engine
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        if (clr) begin
            w_state_nxt = c_s_idle;
            w_ptr_nxt   = 3'd0;
        end else begin
            case (r_state)
                c_s_idle: begin
                    if (burst_start) begin
                        w_state_nxt = c_s_fill;
                        w_ptr_nxt   = 3'd0;
                    end
                end
                c_s_fill: begin
                    if (s_valid) begin
                        if (r_ptr == c_ptr_last) begin
                            w_state_nxt = c_s_done;
                        end else begin
                            w_ptr_nxt = r_ptr + 3'd1;
                        end
                    end
                end
                c_s_done: begin
                    w_state_nxt = c_s_idle;
                end
                default: begin
                    w_state_nxt = c_s_idle;
                    w_ptr_nxt   = 3'd0;
                end
            endcase
        end
    end

    // State, pointer and error-pulse registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= c_s_idle;
            r_ptr    <= 3'd0;
            r_wr_err <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_ptr    <= w_ptr_nxt;
            r_wr_err <= w_wr_err_nxt;
        end
    end

    // Register array: clear, single write (IDLE only) or stream accept (FILL
    // only); the two write sources are mutually exclusive by state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) begin
                r_regs[i] <= '0;
            end
        end else if (clr) begin
            for (int i = 0; i < 8; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_single) begin
            r_regs[wsel[2:0]] <= wdata;
        end else if (w_accept) begin
            r_regs[r_ptr] <= s_data;
        end
    end

    assign s_ready = (r_state == c_s_fill);
    assign busy    = !w_idle;
    assign done    = (r_state == c_s_done);
    assign wr_err  = r_wr_err;

    assign r0 = r_regs[0];
    assign r1 = r_regs[1];
    assign r2 = r_regs[2];
    assign r3 = r_regs[3];
    assign r4 = r_regs[4];
    assign r5 = r_regs[5];
    assign r6 = r_regs[6];
    assign r7 = r_regs[7];

endmodule
`default_nettype wire

// File: tb/tb_reg8_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg8_bank
// Purpose  : Self-checking bench for reg8_bank: table-driven single writes,
//            hand-written burst, collision, clear-abort and simultaneous-start
//            sequences, checked through an expected-result queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reg8_bank;

    logic       clk;
    logic       rst_n;
    logic       clr;
    logic       we;
    logic [3:0] wsel;
    logic [7:0] wdata;
    logic       burst_start;
    logic       s_valid;
    logic [7:0] s_data;
    logic       s_ready;
    logic       busy;
    logic       done;
    logic       wr_err;
    logic [7:0] r0, r1, r2, r3, r4, r5, r6, r7;
    logic [7:0] dr [8];

    int n_checks = 0;
    int n_fail   = 0;

    // Bench-side model of register contents
    logic [7:0] m [8];

    typedef struct {
        string      name;
        logic [7:0] regs [8];
        logic       wr_err;
        logic       busy;
        logic       done;
        logic       s_ready;
    } exp_t;

    exp_t sb [$];

    typedef struct {
        logic       we;
        logic [3:0] wsel;
        logic [7:0] wdata;
        logic       exp_err;
    } vec_t;

    vec_t vecs [9];

    reg8_bank #(.WIDTH(8), .SEL_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .we(we), .wsel(wsel),
        .wdata(wdata), .burst_start(burst_start), .s_valid(s_valid),
        .s_data(s_data), .s_ready(s_ready), .busy(busy), .done(done),
        .wr_err(wr_err), .r0(r0), .r1(r1), .r2(r2), .r3(r3), .r4(r4),
        .r5(r5), .r6(r6), .r7(r7)
    );

    assign dr[0] = r0; assign dr[1] = r1; assign dr[2] = r2; assign dr[3] = r3;
    assign dr[4] = r4; assign dr[5] = r5; assign dr[6] = r6; assign dr[7] = r7;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic chk_regs(input string nm, input logic [7:0] exp_regs [8]);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("%s r%0d", nm, i), 32'(dr[i]), 32'(exp_regs[i]));
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < 8; i++) m[i] = 8'h00;
    endtask

    // Push the expected post-edge state, take one edge, then pop and compare.
    task automatic cyc(input string nm, input logic e_err, input logic e_busy,
                       input logic e_done, input logic e_rdy);
        exp_t e;
        e.name    = nm;
        e.regs    = m;
        e.wr_err  = e_err;
        e.busy    = e_busy;
        e.done    = e_done;
        e.s_ready = e_rdy;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk({nm, " scoreboard empty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            chk_regs(e.name, e.regs);
            chk({e.name, " wr_err"},  32'(wr_err),  32'(e.wr_err));
            chk({e.name, " busy"},    32'(busy),    32'(e.busy));
            chk({e.name, " done"},    32'(done),    32'(e.done));
            chk({e.name, " s_ready"}, 32'(s_ready), 32'(e.s_ready));
        end
    endtask

    task automatic idle_inputs();
        clr = 1'b0; we = 1'b0; wsel = 4'd0; wdata = 8'h00;
        burst_start = 1'b0; s_valid = 1'b0; s_data = 8'h00;
    endtask

    initial begin
        vecs[0] = '{we:1'b1, wsel:4'd3,  wdata:8'hA5, exp_err:1'b0};
        vecs[1] = '{we:1'b1, wsel:4'd7,  wdata:8'h3C, exp_err:1'b0};
        vecs[2] = '{we:1'b1, wsel:4'd9,  wdata:8'hFF, exp_err:1'b1};
        vecs[3] = '{we:1'b0, wsel:4'd9,  wdata:8'hFF, exp_err:1'b0};
        vecs[4] = '{we:1'b1, wsel:4'd15, wdata:8'h11, exp_err:1'b1};
        vecs[5] = '{we:1'b1, wsel:4'd8,  wdata:8'h22, exp_err:1'b1};
        vecs[6] = '{we:1'b1, wsel:4'd0,  wdata:8'h01, exp_err:1'b0};
        vecs[7] = '{we:1'b1, wsel:4'd0,  wdata:8'h02, exp_err:1'b0};
        vecs[8] = '{we:1'b0, wsel:4'd2,  wdata:8'h77, exp_err:1'b0};

        idle_inputs();
        clear_model();
        rst_n = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk_regs("reset", m);
        chk("reset s_ready", 32'(s_ready), 32'd0);
        chk("reset busy",    32'(busy),    32'd0);
        chk("reset done",    32'(done),    32'd0);
        chk("reset wr_err",  32'(wr_err),  32'd0);
        rst_n = 1'b1;
        cyc("post-reset", 1'b0, 1'b0, 1'b0, 1'b0);

        // Single writes from the vector table
        for (int k = 0; k < 9; k++) begin
            we = vecs[k].we; wsel = vecs[k].wsel; wdata = vecs[k].wdata;
            if (vecs[k].we && vecs[k].wsel < 4'd8) m[vecs[k].wsel[2:0]] = vecs[k].wdata;
            cyc($sformatf("single[%0d]", k), vecs[k].exp_err, 1'b0, 1'b0, 1'b0);
        end
        idle_inputs();

        // Asynchronous reset between edges clears without a clock edge
        #2;
        rst_n = 1'b0;
        #1;
        clear_model();
        chk_regs("async reset", m);
        chk("async reset busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc("after async reset", 1'b0, 1'b0, 1'b0, 1'b0);

        // Burst fill with a 2-cycle stall after the 3rd byte, plus collisions
        burst_start = 1'b1;
        cyc("burst start", 1'b0, 1'b1, 1'b0, 1'b1);
        burst_start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            s_valid = 1'b1;
            s_data  = 8'h10 + 8'(i);
            m[i]    = s_data;
            if (i == 4) begin
                we = 1'b1; wsel = 4'd0; wdata = 8'hEE; burst_start = 1'b1;
            end
            if (i < 7) cyc($sformatf("burst byte %0d", i), i == 4, 1'b1, 1'b0, 1'b1);
            else       cyc("burst last byte", 1'b0, 1'b1, 1'b1, 1'b0);
            we = 1'b0; burst_start = 1'b0;
            if (i == 2) begin
                s_valid = 1'b0; s_data = 8'hCC;
                cyc("stall 1", 1'b0, 1'b1, 1'b0, 1'b1);
                cyc("stall 2", 1'b0, 1'b1, 1'b0, 1'b1);
            end
        end
        // Write during the DONE cycle is rejected
        s_valid = 1'b0;
        we = 1'b1; wsel = 4'd2; wdata = 8'h99;
        cyc("write in DONE", 1'b1, 1'b0, 1'b0, 1'b0);
        idle_inputs();
        cyc("burst idle", 1'b0, 1'b0, 1'b0, 1'b0);

        // Clear abort after 4 bytes accepted
        burst_start = 1'b1;
        cyc("burst2 start", 1'b0, 1'b1, 1'b0, 1'b1);
        burst_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            s_valid = 1'b1; s_data = 8'h20 + 8'(i); m[i] = s_data;
            cyc($sformatf("burst2 byte %0d", i), 1'b0, 1'b1, 1'b0, 1'b1);
        end
        clr = 1'b1; s_valid = 1'b1; s_data = 8'h99;
        we = 1'b1; wsel = 4'd1; wdata = 8'h44; burst_start = 1'b1;
        clear_model();
        cyc("clr abort", 1'b0, 1'b0, 1'b0, 1'b0);
        idle_inputs();
        cyc("after clr", 1'b0, 1'b0, 1'b0, 1'b0);

        // Following burst starts from r0
        burst_start = 1'b1;
        cyc("burst3 start", 1'b0, 1'b1, 1'b0, 1'b1);
        burst_start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            s_valid = 1'b1; s_data = 8'h30 + 8'(i); m[i] = s_data;
            cyc($sformatf("burst3 byte %0d", i), 1'b0, 1'b1, i == 7, i != 7);
        end
        s_valid = 1'b0;
        cyc("burst3 idle", 1'b0, 1'b0, 1'b0, 1'b0);

        // Simultaneous single write and burst start in IDLE
        we = 1'b1; wsel = 4'd5; wdata = 8'h5A; burst_start = 1'b1;
        m[5] = 8'h5A;
        cyc("simultaneous", 1'b0, 1'b1, 1'b0, 1'b1);
        idle_inputs();
        cyc("simultaneous hold", 1'b0, 1'b1, 1'b0, 1'b1);
        clr = 1'b1;
        clear_model();
        cyc("final clr", 1'b0, 1'b0, 1'b0, 1'b0);
        idle_inputs();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
